uart_rx_autobaud: RTL and testbench

Auto-baud controller that configures and sequences the 8N1 UART receiver datapath.
- Measures the bit period from a 0x55 sync character on the raw rx line and programs the receiver's clk_ratio.
- Gates the receiver enable and confirms lock with a second 0x55 received through the datapath.
- Forwards received bytes once locked; drops lock and re-hunts on repeated framing errors or on host request.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_autobaud_if.sv | 37 +++
 rtl/sync.sv | 24 ++
 rtl/uart_baud_meas.sv | 77 +++++++
 rtl/uart_rx_autobaud.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_autobaud.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the auto-baud controller: one-hot state encoding,
// sync character and measurement constants.
package uart_pkg;

    localparam int HUNT      = 0;
    localparam int MEASURE   = 1;
    localparam int WAIT_STOP = 2;
    localparam int VERIFY    = 3;
    localparam int LOCKED    = 4;
    localparam int N_STATES  = 5;

    typedef enum logic [N_STATES-1:0] {
        S_HUNT      = 5'b1 << HUNT,
        S_MEASURE   = 5'b1 << MEASURE,
        S_WAIT_STOP = 5'b1 << WAIT_STOP,
        S_VERIFY    = 5'b1 << VERIFY,
        S_LOCKED    = 5'b1 << LOCKED
    } state_e;

    localparam logic [7:0] SYNC_CHAR  = 8'h55;
    localparam int         TIMER_W    = 11;
    localparam int         MEAS_EDGES = 5;

endpackage

// File: rtl/uart_rx_autobaud_if.sv
// Signal bundle between the auto-baud controller, the receiver datapath and the host.
// Optional UART_AUTOBAUD_MANUAL_EN adds the manual_en / manual_ratio override inputs.
interface uart_rx_autobaud_if;

    logic       rx;
    logic       cal_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] clk_ratio;
    logic       rx_enable;
    logic       locked;
    logic [7:0] out_data;
    logic       out_valid;
    logic       meas_fail;
`ifdef UART_AUTOBAUD_MANUAL_EN
    logic       manual_en;
    logic [7:0] manual_ratio;
`endif

    modport slave (
        input  rx, cal_req, rx_data, rx_valid, rx_error,
        output clk_ratio, rx_enable, locked, out_data, out_valid, meas_fail
`ifdef UART_AUTOBAUD_MANUAL_EN
        , input manual_en, manual_ratio
`endif
    );

    modport master (
        output rx, cal_req, rx_data, rx_valid, rx_error,
        input  clk_ratio, rx_enable, locked, out_data, out_valid, meas_fail
`ifdef UART_AUTOBAUD_MANUAL_EN
        , output manual_en, manual_ratio
`endif
    );

endinterface

// File: rtl/sync.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_baud_meas.sv
// Bit-period measurement over a 0x55 sync character: edge detection on the
// synchronized line, span timer, falling-edge counter and rounded range check.
module uart_baud_meas
    import uart_pkg::*;
#(
    parameter int MIN_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       measuring,
    output logic       fall,
    output logic       rise,
    output logic       done,
    output logic       fail,
    output logic [7:0] ratio
);

    localparam logic [2:0]       LAST_EDGE = 3'(MEAS_EDGES - 2);
    localparam logic [TIMER_W:0] P_MIN     = (TIMER_W+1)'(MIN_BIT);
    localparam logic [TIMER_W:0] P_MAX     = (TIMER_W+1)'(256);

    logic               rx_s;
    logic               rx_prev;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         edge_cnt;
    logic [TIMER_W:0]   rounded;
    logic               last_edge;
    logic               timed_out;
    logic               in_range;

    // Idle line is high, so reset to 1 to avoid a spurious falling edge.
    sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign rise = ~rx_prev & rx_s;

    // Counter only counts edges after the one that started the measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            edge_cnt <= '0;
        end else if (!measuring) begin
            timer    <= '0;
            edge_cnt <= '0;
        end else begin
            if (timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end
            if (fall) begin
                edge_cnt <= edge_cnt + 3'd1;
            end
        end
    end

    assign last_edge = measuring & fall & (edge_cnt == LAST_EDGE);
    assign timed_out = measuring & (timer == '1);
    assign rounded   = ({1'b0, timer} + (TIMER_W+1)'(4)) >> 3;
    assign in_range  = (rounded >= P_MIN) && (rounded <= P_MAX);
    assign done      = last_edge & in_range;
    assign fail      = (last_edge & ~in_range) | (timed_out & ~last_edge);
    assign ratio     = 8'(rounded - (TIMER_W+1)'(1));

endmodule

// File: rtl/uart_rx_autobaud.sv
// Auto-baud controller: measures a sync char, programs and verifies the receiver,
// then forwards bytes until re-hunt. Optional UART_AUTOBAUD_MANUAL_EN adds a manual override.
module uart_rx_autobaud
    import uart_pkg::*;
#(
    parameter logic [7:0] DEFAULT_RATIO = 8'd15,
    parameter int         MIN_BIT       = 4,
    parameter int         ERR_LIMIT     = 3
) (
    input logic                clk,
    input logic                rst_n,
    uart_rx_autobaud_if.slave  bus
);

    localparam logic [3:0] ERR_LAST = 4'(ERR_LIMIT - 1);

    state_e     state, state_next;
    logic [7:0] clk_ratio_q, clk_ratio_next;
    logic       rx_enable_q, rx_enable_next;
    logic       locked_q, locked_next;
    logic [7:0] out_data_q, out_data_next;
    logic       out_valid_q, out_valid_next;
    logic       meas_fail_q, meas_fail_next;
    logic [3:0] err_cnt_q, err_cnt_next;

    logic       fall;
    logic       rise;
    logic       meas_done;
    logic       meas_bad;
    logic [7:0] meas_ratio;

    uart_baud_meas #(.MIN_BIT(MIN_BIT)) u_meas (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (bus.rx),
        .measuring (state == S_MEASURE),
        .fall      (fall),
        .rise      (rise),
        .done      (meas_done),
        .fail      (meas_bad),
        .ratio     (meas_ratio)
    );

`ifdef UART_AUTOBAUD_MANUAL_EN
    logic manual_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            manual_q <= 1'b0;
        end else begin
            manual_q <= bus.manual_en;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            clk_ratio_q <= DEFAULT_RATIO;
            rx_enable_q <= 1'b0;
            locked_q    <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            meas_fail_q <= 1'b0;
            err_cnt_q   <= 4'd0;
        end else begin
            state       <= state_next;
            clk_ratio_q <= clk_ratio_next;
            rx_enable_q <= rx_enable_next;
            locked_q    <= locked_next;
            out_data_q  <= out_data_next;
            out_valid_q <= out_valid_next;
            meas_fail_q <= meas_fail_next;
            err_cnt_q   <= err_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        clk_ratio_next = clk_ratio_q;
        rx_enable_next = rx_enable_q;
        locked_next    = locked_q;
        out_data_next  = out_data_q;
        out_valid_next = 1'b0;
        meas_fail_next = 1'b0;
        err_cnt_next   = err_cnt_q;

        case (state)
            S_HUNT: begin
                rx_enable_next = 1'b0;
                locked_next    = 1'b0;
                err_cnt_next   = 4'd0;
                if (fall) begin
                    state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (meas_bad) begin
                    meas_fail_next = 1'b1;
                    state_next     = S_HUNT;
                end else if (meas_done) begin
                    clk_ratio_next = meas_ratio;
                    state_next     = S_WAIT_STOP;
                end
            end
            // Enabling only on the stop bit keeps the receiver from seeing the sync char mid-frame.
            S_WAIT_STOP: begin
                if (rise) begin
                    rx_enable_next = 1'b1;
                    state_next     = S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == SYNC_CHAR && !bus.rx_error) begin
                        locked_next  = 1'b1;
                        err_cnt_next = 4'd0;
                        state_next   = S_LOCKED;
                    end else begin
                        meas_fail_next = 1'b1;
                        clk_ratio_next = DEFAULT_RATIO;
                        rx_enable_next = 1'b0;
                        state_next     = S_HUNT;
                    end
                end
            end
            S_LOCKED: begin
                if (bus.rx_valid) begin
                    if (!bus.rx_error) begin
                        out_data_next  = bus.rx_data;
                        out_valid_next = 1'b1;
                        err_cnt_next   = 4'd0;
                    end else if (err_cnt_q == ERR_LAST) begin
                        locked_next    = 1'b0;
                        rx_enable_next = 1'b0;
                        clk_ratio_next = DEFAULT_RATIO;
                        err_cnt_next   = 4'd0;
                        state_next     = S_HUNT;
                    end else begin
                        err_cnt_next = err_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_next     = S_HUNT;
                clk_ratio_next = DEFAULT_RATIO;
                rx_enable_next = 1'b0;
                locked_next    = 1'b0;
                err_cnt_next   = 4'd0;
            end
        endcase

        // Host recalibration wins over anything the datapath delivers this cycle.
        if (bus.cal_req) begin
            state_next     = S_HUNT;
            clk_ratio_next = DEFAULT_RATIO;
            rx_enable_next = 1'b0;
            locked_next    = 1'b0;
            out_data_next  = out_data_q;
            out_valid_next = 1'b0;
            meas_fail_next = 1'b0;
            err_cnt_next   = 4'd0;
        end

`ifdef UART_AUTOBAUD_MANUAL_EN
        if (bus.manual_en) begin
            state_next     = S_LOCKED;
            clk_ratio_next = bus.manual_ratio;
            rx_enable_next = 1'b1;
            locked_next    = 1'b1;
            meas_fail_next = 1'b0;
            err_cnt_next   = 4'd0;
        end else if (manual_q) begin
            state_next     = S_HUNT;
            clk_ratio_next = DEFAULT_RATIO;
            rx_enable_next = 1'b0;
            locked_next    = 1'b0;
            err_cnt_next   = 4'd0;
        end
`endif
    end

    assign bus.clk_ratio = clk_ratio_q;
    assign bus.rx_enable = rx_enable_q;
    assign bus.locked    = locked_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.meas_fail = meas_fail_q;

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Randomized self-checking bench for uart_rx_autobaud: drives sync characters on rx,
// plays the receiver datapath, and predicts ratio/lock/forwarding from bit timing.
module tb_uart_rx_autobaud;

    localparam logic [7:0] DEF_RATIO = 8'd15;
    localparam int         MIN_BIT   = 4;
    localparam int         ERR_LIMIT = 3;
    localparam logic [7:0] SYNC      = 8'h55;

    logic clk;
    logic rst_n;

    uart_rx_autobaud_if bus();

    uart_rx_autobaud #(
        .DEFAULT_RATIO (DEF_RATIO),
        .MIN_BIT       (MIN_BIT),
        .ERR_LIMIT     (ERR_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         failCount   = 0;
    int         enableCount = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid) got_q.push_back(bus.out_data);
        if (bus.meas_fail) failCount++;
        if (bus.rx_enable) enableCount++;
    end

    initial begin
        #(10 * 95000);
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Serial 8N1 frame; jitter moves inner bit boundaries but keeps the 1st-to-5th fall span exact.
    task automatic applyStimulus(input logic [7:0] data, input int bitClks, input int jitter);
        int         t [0:10];
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int k = 0; k <= 10; k++) begin
            t[k] = k * bitClks;
            if (jitter > 0 && k != 0 && k != 8 && k != 10)
                t[k] += int'($urandom_range(32'(2 * jitter), 0)) - jitter;
        end
        for (int k = 0; k < 10; k++) begin
            bus.rx = frame[k];
            tick(t[k+1] - t[k]);
        end
        bus.rx = 1'b1;
    endtask

    task automatic deliverByte(input logic [7:0] data, input bit err);
        bus.rx_data  = data;
        bus.rx_error = err;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic waitForEnable(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (bus.rx_enable) seen = 1'b1;
            else tick(1);
        end
    endtask

    task automatic calibrate();
        bus.cal_req = 1'b1;
        tick(1);
        bus.cal_req = 1'b0;
    endtask

    task automatic compareStream();
        checkOutput("fwd_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            checkOutput("fwd_data", got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic acquireLock(input int bitClks, input int jitter);
        bit seen;
        applyStimulus(SYNC, bitClks, jitter);
        waitForEnable(64, seen);
        checkOutput("enable", seen, 1);
        checkOutput("ratio", bus.clk_ratio, bitClks - 1);
        deliverByte(SYNC, 1'b0);
        checkOutput("locked", bus.locked, 1);
    endtask

    // Model: good byte forwarded and clears the run; ERR_LIMIT errors in a row drop lock.
    task automatic runTraffic(input int frames, input bit useMask, input logic [15:0] mask);
        int         errRun;
        int         gap;
        int         fc;
        bit         lockedModel;
        bit         err;
        logic [7:0] data;
        errRun      = 0;
        lockedModel = 1'b1;
        fc          = failCount;
        for (int i = 0; i < frames; i++) begin
            data = 8'($urandom);
            err  = useMask ? mask[i] : ($urandom_range(3, 0) == 0);
            deliverByte(data, err);
            if (err) begin
                errRun++;
                if (errRun >= ERR_LIMIT) lockedModel = 1'b0;
            end else begin
                errRun = 0;
                exp_q.push_back(data);
            end
            checkOutput("traffic_locked", bus.locked, lockedModel);
            if (!lockedModel) begin
                checkOutput("drop_ratio", bus.clk_ratio, DEF_RATIO);
                checkOutput("drop_enable", bus.rx_enable, 0);
                break;
            end
            gap = $urandom_range(2, 0);
            tick(gap);
        end
        tick(1);
        checkOutput("traffic_no_measfail", failCount, fc);
        compareStream();
    endtask

    initial begin
        bit seen;
        int cycles;
        int fc;
        int ec;
        bus.rx       = 1'b1;
        bus.cal_req  = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
`ifdef UART_AUTOBAUD_MANUAL_EN
        bus.manual_en    = 1'b0;
        bus.manual_ratio = 8'h00;
`endif
        rst_n = 1'b0;
        tick(2);
        checkOutput("rst_ratio", bus.clk_ratio, DEF_RATIO);
        checkOutput("rst_enable", bus.rx_enable, 0);
        checkOutput("rst_locked", bus.locked, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_meas_fail", bus.meas_fail, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        $display("[TB] lock at 16 clk/bit and forward 0xA3");
        acquireLock(16, 0);
        deliverByte(8'hA3, 1'b0);
        exp_q.push_back(8'hA3);
        checkOutput("a3_valid", bus.out_valid, 1);
        checkOutput("a3_data", bus.out_data, 8'hA3);
        tick(1);
        checkOutput("a3_valid_drop", bus.out_valid, 0);
        compareStream();

        $display("[TB] error patterns");
        runTraffic(5, 1'b1, 16'b01101);
        checkOutput("pattern_stays_locked", bus.locked, 1);
        runTraffic(3, 1'b1, 16'b00111);
        checkOutput("pattern_dropped", bus.locked, 0);

        $display("[TB] lock at 100 clk/bit with jitter");
        acquireLock(100, 2);
        deliverByte(8'h3C, 1'b0);
        exp_q.push_back(8'h3C);
        tick(1);
        compareStream();

        $display("[TB] cal_req with same-cycle rx_valid");
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        bus.cal_req  = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.cal_req  = 1'b0;
        checkOutput("cal_locked", bus.locked, 0);
        checkOutput("cal_enable", bus.rx_enable, 0);
        checkOutput("cal_ratio", bus.clk_ratio, DEF_RATIO);
        checkOutput("cal_out_data", bus.out_data, 8'h3C);
        deliverByte(8'h11, 1'b0);
        tick(1);
        compareStream();

        $display("[TB] verify rejects a wrong second character");
        applyStimulus(SYNC, 24, 0);
        waitForEnable(64, seen);
        checkOutput("vfy_enable", seen, 1);
        checkOutput("vfy_ratio", bus.clk_ratio, 23);
        fc = failCount;
        deliverByte(8'h5A, 1'b0);
        tick(1);
        checkOutput("vfy_measfail", failCount, fc + 1);
        checkOutput("vfy_ratio_reset", bus.clk_ratio, DEF_RATIO);
        checkOutput("vfy_enable_off", bus.rx_enable, 0);
        checkOutput("vfy_locked", bus.locked, 0);

        $display("[TB] line held low past the timer limit");
        bus.rx = 1'b0;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 2300) begin
            tick(1);
            cycles++;
            if (bus.meas_fail) seen = 1'b1;
        end
        checkOutput("timeout_fail", seen, 1);
        checkOutput("timeout_window", (cycles >= 2047 && cycles <= 2056), 1);
        checkOutput("timeout_ratio", bus.clk_ratio, DEF_RATIO);
        checkOutput("timeout_enable", bus.rx_enable, 0);
        bus.rx = 1'b1;
        tick(5);

        $display("[TB] sync at 2 clk/bit is below the minimum");
        fc = failCount;
        ec = enableCount;
        applyStimulus(SYNC, 2, 0);
        tick(10);
        checkOutput("minbit_fail", failCount, fc + 1);
        checkOutput("minbit_no_enable", enableCount, ec);
        checkOutput("minbit_ratio", bus.clk_ratio, DEF_RATIO);

        $display("[TB] asynchronous reset mid-measurement");
        checkOutput("pre_rst_data", bus.out_data, 8'h3C);
        bus.rx = 1'b0;
        tick(20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_data", bus.out_data, 0);
        checkOutput("arst_ratio", bus.clk_ratio, DEF_RATIO);
        checkOutput("arst_enable", bus.rx_enable, 0);
        checkOutput("arst_locked", bus.locked, 0);
        bus.rx = 1'b1;
        tick(2);
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        $display("[TB] randomized lock and traffic");
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(40, MIN_BIT);
            acquireLock(n, 0);
            runTraffic(12, 1'b0, 16'h0000);
            if (bus.locked) calibrate();
            tick(4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
